nrzi_rx: RTL and testbench
==========================

# nrzi_rx

Receive-side line front end for the UTMI datapath: samples the differential pair once per bit clock, hunts for the SYNC pattern, NRZI-decodes the packet body, and detects end-of-packet (EOP). Its decoded bit stream, qualified by `bit_valid`, feeds the bit-unstuff/deserializer stage (`sh_bus`) directly downstream. Stuff bits are passed through, not removed; this block only flags stuffing violations.

## Interface
- `STUFF_LIMIT`, 7: consecutive decoded 1s that constitute a stuffing error.
- `EOP_SE0_MIN`, 2: minimum SE0 bit-times before J for a valid EOP.
- `clk`  in  1  bit-rate clock; one line sample per rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dp`  in  1  D+ line sample, already synchronized to `clk`.
- `dm`  in  1  D- line sample, already synchronized to `clk`.
- `dataOut`  out  1  NRZI-decoded bit; meaningful only when `bit_valid`=1.
- `bit_valid`  out  1  `dataOut` carries a packet-body bit this cycle.
- `rx_active`  out  1  packet in progress (SYNC seen, EOP/error not yet).
- `sop`  out  1  one-cycle pulse: SYNC completed.
- `eop`  out  1  one-cycle pulse: valid EOP completed.
- `rx_error`  out  1  one-cycle pulse: packet aborted.

## Operation
- Line symbols: J = {dp,dm}=10, K = 01, SE0 = 00, SE1 = 11 (always illegal).
- Register `prev` holds last J/K symbol; reset value J.
- States: IDLE, SYNC, DATA, EOP.
- IDLE: `prev` tracks line every cycle. K with `prev`=J -> SYNC, index=1. All outputs idle.
- SYNC: expected symbols at index 1..7: J,K,J,K,J,K,K (full pattern KJKJKJKK). Match -> index+1; match at index 7 -> DATA, `sop` pulse, `rx_active` rises. Any mismatch, SE0 or SE1 -> IDLE silently (no `rx_error`). SYNC bits never produce `bit_valid`.
- DATA: J/K sample -> `dataOut` = 1 if symbol equals `prev`, else 0; `bit_valid`=1; `prev` updated. Ones counter: +1 on 1, cleared on 0; reaching `STUFF_LIMIT` -> `rx_error`, IDLE (the 7th bit is still output with `bit_valid`). SE0 -> EOP, se0_cnt=1, no `bit_valid`. SE1 -> `rx_error`, IDLE.
- EOP: SE0 -> se0_cnt+1 (saturating). J with se0_cnt >= `EOP_SE0_MIN` -> `eop`, IDLE, `prev`=J. J with se0_cnt < min, K, or SE1 -> `rx_error`, IDLE.
- On every return to IDLE, ones counter, index and se0_cnt clear; `prev` set to J only on valid EOP, otherwise keeps tracking line.
- `eop` and `rx_error` never assert in the same cycle; `sop` never coincides with either.

## Timing
- All outputs registered; each reflects the line sample of the previous edge (latency 1 cycle).
- Reset values: `dataOut`=0, `bit_valid`=0, `rx_active`=0, `sop`=0, `eop`=0, `rx_error`=0; state IDLE, `prev`=J, counters 0.
- `rx_active` high from the `sop` cycle through the `eop`/`rx_error` cycle inclusive; low the following cycle.
- `dataOut` holds its last value when `bit_valid`=0.
- First body bit: `bit_valid` earliest one cycle after `sop`.
- `rst_n` low mid-packet: next edge forces all reset values, no `eop`/`rx_error` pulse.
- Back-to-back packets: new SYNC may start on the sample immediately after the EOP's J.

## Structure
- Shared package `utmi_pkg`: line-symbol encodings (J, K, SE0, SE1), SYNC symbol sequence constant, state enum, default `STUFF_LIMIT`/`EOP_SE0_MIN`.
- Single module; no sub-module. Line-symbol classification is a small combinational function in `utmi_pkg`.

## Test plan
- Idle J, then KJKJKJKK, body symbols K,K,J,J, SE0,SE0,J -> `sop` once; `dataOut`/`bit_valid` = 1,0... exactly: 1 (K after K),1,0,1; then `eop` pulse; `rx_active` drops next cycle.
- SYNC corrupted (KJKJJ...) -> no `sop`, no `rx_error`; following clean SYNC accepted.
- Body with 7 unchanged symbols after SYNC -> seven 1s output, `rx_error` on the 7th, `rx_active` low next cycle.
- Single SE0 then J -> `rx_error`, no `eop`; SE1 in DATA -> `rx_error`.
- `rst_n` low for one cycle mid-body -> all outputs 0 next cycle, no pulses; next SYNC recognized.
- Two packets separated by only the EOP's J -> two `sop`, two `eop`, no errors.

Source files
------------

// File: rtl/utmi_pkg.sv
// rtl/utmi_pkg.sv - line symbols, SYNC sequence, receiver states and defaults
package utmi_pkg;

  // Line symbols as {dp,dm}
  typedef enum logic [1:0] {
    SYM_SE0 = 2'b00,
    SYM_K   = 2'b01,
    SYM_J   = 2'b10,
    SYM_SE1 = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } state_t;

  // SYNC as symbols 0..7, most significant pair first: K J K J K J K K
  localparam logic [15:0] SYNC_SEQ = {SYM_K, SYM_J, SYM_K, SYM_J,
                                      SYM_K, SYM_J, SYM_K, SYM_K};

  localparam int DEF_STUFF_LIMIT = 7;
  localparam int DEF_EOP_SE0_MIN = 2;

  // Classify one synchronized line sample
  function automatic sym_t classify(input logic dp, input logic dm);
    return sym_t'({dp, dm});
  endfunction

  // Expected SYNC symbol at position idx (0 is the opening K)
  function automatic sym_t sync_sym(input logic [2:0] idx);
    return sym_t'(SYNC_SEQ[{3'd7 - idx, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/nrzi_rx_if.sv
// rtl/nrzi_rx_if.sv - line inputs and decoded-bit outputs of the receiver
interface nrzi_rx_if;
  logic dp;
  logic dm;
  logic dataOut;
  logic bit_valid;
  logic rx_active;
  logic sop;
  logic eop;
  logic rx_error;

  // Line side drives dp/dm and observes the decoded stream
  modport master (
    output dp, dm,
    input  dataOut, bit_valid, rx_active, sop, eop, rx_error
  );

  // Receiver side samples dp/dm and produces the decoded stream
  modport slave (
    input  dp, dm,
    output dataOut, bit_valid, rx_active, sop, eop, rx_error
  );
endinterface

// File: rtl/nrzi_rx.sv
// rtl/nrzi_rx.sv - SYNC hunt, NRZI decode, stuffing check and EOP detection
import utmi_pkg::*;

module nrzi_rx #(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT,
  parameter int EOP_SE0_MIN = DEF_EOP_SE0_MIN
) (
  input  logic   clk,
  input  logic   rst_n,
  nrzi_rx_if.slave bus
);

  localparam logic [3:0] ONES_LIM = 4'(STUFF_LIMIT);
  localparam logic [3:0] SE0_MIN  = 4'(EOP_SE0_MIN);

  state_t     state;
  sym_t       prev;
  sym_t       sym;
  logic [2:0] idx;
  logic [3:0] ones_cnt;
  logic [3:0] ones_inc;
  logic [3:0] se0_cnt;
  logic       data_r;
  logic       valid_r;
  logic       active_r;
  logic       sop_r;
  logic       eop_r;
  logic       err_r;

  assign sym      = classify(bus.dp, bus.dm);
  assign ones_inc = ones_cnt + 4'd1;

  assign bus.dataOut   = data_r;
  assign bus.bit_valid = valid_r;
  assign bus.rx_active = active_r;
  assign bus.sop       = sop_r;
  assign bus.eop       = eop_r;
  assign bus.rx_error  = err_r;

  // Receiver FSM: every output is registered from the current line sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      prev     <= SYM_J;
      idx      <= 3'd0;
      ones_cnt <= 4'd0;
      se0_cnt  <= 4'd0;
      data_r   <= 1'b0;
      valid_r  <= 1'b0;
      active_r <= 1'b0;
      sop_r    <= 1'b0;
      eop_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;

      // prev follows every J/K on the line; a valid EOP ends on J anyway
      if (sym == SYM_J || sym == SYM_K) prev <= sym;

      case (state)
        ST_IDLE: begin
          active_r <= 1'b0;
          idx      <= 3'd0;
          ones_cnt <= 4'd0;
          se0_cnt  <= 4'd0;
          if (sym == SYM_K && prev == SYM_J) begin
            state <= ST_SYNC;
            idx   <= 3'd1;
          end
        end

        ST_SYNC: begin
          if (sym == sync_sym(idx)) begin
            if (idx == 3'd7) begin
              state    <= ST_DATA;
              sop_r    <= 1'b1;
              active_r <= 1'b1;
              idx      <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            // A broken SYNC is just line noise, not a packet error
            state <= ST_IDLE;
            idx   <= 3'd0;
          end
        end

        ST_DATA: begin
          case (sym)
            SYM_J, SYM_K: begin
              valid_r <= 1'b1;
              data_r  <= (sym == prev);
              if (sym == prev) begin
                if (ones_inc == ONES_LIM) begin
                  err_r    <= 1'b1;
                  state    <= ST_IDLE;
                  ones_cnt <= 4'd0;
                end else begin
                  ones_cnt <= ones_inc;
                end
              end else begin
                ones_cnt <= 4'd0;
              end
            end
            SYM_SE0: begin
              state   <= ST_EOP;
              se0_cnt <= 4'd1;
            end
            default: begin
              err_r    <= 1'b1;
              state    <= ST_IDLE;
              ones_cnt <= 4'd0;
            end
          endcase
        end

        ST_EOP: begin
          case (sym)
            SYM_SE0: begin
              if (se0_cnt != 4'hF) se0_cnt <= se0_cnt + 4'd1;
            end
            SYM_J: begin
              if (se0_cnt >= SE0_MIN) eop_r <= 1'b1;
              else                    err_r <= 1'b1;
              state    <= ST_IDLE;
              se0_cnt  <= 4'd0;
              ones_cnt <= 4'd0;
            end
            default: begin
              err_r    <= 1'b1;
              state    <= ST_IDLE;
              se0_cnt  <= 4'd0;
              ones_cnt <= 4'd0;
            end
          endcase
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_rx.sv
// tb/tb_nrzi_rx.sv - directed line vectors checked against a packet-parsing model
module tb_nrzi_rx;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] SE1 = 2'b11;
  localparam int MAXN = 512;

  logic clk = 1'b0;
  logic rst_n;

  nrzi_rx_if bus();

  nrzi_rx #(.STUFF_LIMIT(7), .EOP_SE0_MIN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] line_q [MAXN];
  bit         rst_q  [MAXN];
  int         n = 0;

  bit e_sop [MAXN+1];
  bit e_eop [MAXN+1];
  bit e_err [MAXN+1];
  bit e_act [MAXN+1];
  bit e_val [MAXN+1];
  bit e_bit [MAXN+1];
  bit e_rst [MAXN+1];
  bit e_dat [MAXN+1];

  logic g_sop [MAXN+1];
  logic g_eop [MAXN+1];
  logic g_err [MAXN+1];
  logic g_act [MAXN+1];
  logic g_val [MAXN+1];
  logic g_dat [MAXN+1];

  int vectors = 0;
  int miscompares = 0;
  int mid_rst_idx = 0;

  int p;
  logic [1:0] pv;

  task automatic push(input logic [1:0] s);
    line_q[n] = s;
    rst_q[n]  = 1'b0;
    n++;
  endtask

  task automatic push_n(input logic [1:0] s, input int cnt);
    for (int i = 0; i < cnt; i++) push(s);
  endtask

  task automatic push_rst();
    line_q[n] = J;
    rst_q[n]  = 1'b1;
    n++;
  endtask

  task automatic push_sync();
    push(K); push(J); push(K); push(J); push(K); push(J); push(K); push(K);
  endtask

  function automatic logic [1:0] sync_exp(input int k);
    case (k)
      1: return J;
      2: return K;
      3: return J;
      4: return K;
      5: return J;
      6: return K;
      default: return K;
    endcase
  endfunction

  function automatic bit is_jk(input logic [1:0] s);
    return (s == J) || (s == K);
  endfunction

  // Consume a SYNC attempt starting at the opening K; 1 when all 8 symbols match
  function automatic bit hunt_sync();
    pv = K;
    p++;
    for (int k = 1; k <= 7; k++) begin
      if (p >= n || rst_q[p]) return 1'b0;
      if (is_jk(line_q[p])) pv = line_q[p];
      if (line_q[p] != sync_exp(k)) begin
        p++;
        return 1'b0;
      end
      p++;
    end
    return 1'b1;
  endfunction

  // Decode a packet body; a bit decoded from sample i shows up at output index i+1
  function automatic void parse_body();
    logic [1:0] s;
    int ones;
    int run;
    bit b;
    ones = 0;
    while (p < n) begin
      if (rst_q[p]) return;
      s = line_q[p];
      if (is_jk(s)) begin
        b = (s == pv);
        pv = s;
        e_val[p+1] = 1'b1;
        e_bit[p+1] = b;
        e_act[p+1] = 1'b1;
        ones = b ? ones + 1 : 0;
        p++;
        if (ones == 7) begin
          e_err[p] = 1'b1;
          return;
        end
      end else if (s == SE1) begin
        e_act[p+1] = 1'b1;
        e_err[p+1] = 1'b1;
        p++;
        return;
      end else begin
        run = 0;
        while (p < n && !rst_q[p] && line_q[p] == SE0) begin
          run++;
          e_act[p+1] = 1'b1;
          p++;
        end
        if (p >= n || rst_q[p]) return;
        s = line_q[p];
        e_act[p+1] = 1'b1;
        if (s == J && run >= 2) e_eop[p+1] = 1'b1;
        else                    e_err[p+1] = 1'b1;
        if (is_jk(s)) pv = s;
        p++;
        return;
      end
    end
  endfunction

  function automatic void run_model();
    bit d;
    for (int c = 0; c <= MAXN; c++) begin
      e_sop[c] = 0; e_eop[c] = 0; e_err[c] = 0; e_act[c] = 0;
      e_val[c] = 0; e_bit[c] = 0; e_rst[c] = 0; e_dat[c] = 0;
    end
    p = 0;
    pv = J;
    while (p < n) begin
      if (rst_q[p]) begin
        e_rst[p+1] = 1'b1;
        pv = J;
        p++;
      end else if (line_q[p] == K && pv == J) begin
        if (hunt_sync()) begin
          e_sop[p] = 1'b1;
          e_act[p] = 1'b1;
          parse_body();
        end
      end else begin
        if (is_jk(line_q[p])) pv = line_q[p];
        p++;
      end
    end
    d = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (e_rst[c]) d = 1'b0;
      if (e_val[c]) d = e_bit[c];
      e_dat[c] = d;
    end
  endfunction

  task automatic check_cycle(input int c);
    logic [5:0] got;
    logic [5:0] exp;
    got = {bus.sop, bus.eop, bus.rx_error, bus.rx_active, bus.bit_valid, bus.dataOut};
    exp = {e_sop[c], e_eop[c], e_err[c], e_act[c], e_val[c], e_dat[c]};
    g_sop[c] = bus.sop;       g_eop[c] = bus.eop;
    g_err[c] = bus.rx_error;  g_act[c] = bus.rx_active;
    g_val[c] = bus.bit_valid; g_dat[c] = bus.dataOut;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle %0d {sop,eop,err,act,valid,data}: got %b expected %b", c, got, exp);
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n_sop;
    int n_eop;
    int n_err;
    int nb;
    int first_eop;
    logic [3:0] t1_bits;

    rst_n  = 1'b0;
    bus.dp = 1'b1;
    bus.dm = 1'b0;

    // reset, idle
    push_rst(); push_rst();
    push_n(J, 3);
    // clean packet: body K K J J -> 1 1 0 1, then EOP
    push_sync(); push(K); push(K); push(J); push(J);
    push(SE0); push(SE0); push(J); push_n(J, 2);
    // corrupted SYNC, then clean packet with a 3-SE0 EOP
    push(K); push(J); push(K); push(J); push(J); push_n(J, 2);
    push_sync(); push(J); push(K); push(SE0); push(SE0); push(SE0); push(J); push(J);
    // seven unchanged symbols: stuffing error on the seventh
    push_sync(); push_n(K, 7); push_n(J, 3);
    // single SE0 before J, then SE1 in body
    push_sync(); push(J); push(SE0); push(J); push_n(J, 2);
    push_sync(); push(K); push(SE1); push_n(J, 2);
    // reset mid-body, then a fresh packet
    push_sync(); push(K); push(K);
    mid_rst_idx = n;
    push_rst(); push_n(J, 2);
    push_sync(); push(K); push(SE0); push(SE0); push(J); push(J);
    // back-to-back packets
    push_sync(); push(J); push(SE0); push(SE0); push(J);
    push_sync(); push(J); push(SE0); push(SE0); push(J); push_n(J, 3);
    // six 1s then a 0: no stuffing error
    push_sync(); push_n(K, 6); push(J); push(SE0); push(SE0); push(J); push_n(J, 2);

    run_model();

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.dp = line_q[i][1];
      bus.dm = line_q[i][0];
      rst_n  = ~rst_q[i];
      @(posedge clk);
      #1;
      check_cycle(i + 1);
    end

    // Hand-computed expectations pinning the whole run
    n_sop = 0; n_eop = 0; n_err = 0;
    for (int c = 1; c <= n; c++) begin
      if (g_sop[c] === 1'b1) n_sop++;
      if (g_eop[c] === 1'b1) n_eop++;
      if (g_err[c] === 1'b1) n_err++;
    end
    lit("sop_count", n_sop, 10);
    lit("eop_count", n_eop, 6);
    lit("err_count", n_err, 3);

    lit("reset_state", int'({g_sop[1], g_eop[1], g_err[1], g_act[1], g_val[1], g_dat[1]}), 0);

    t1_bits = 4'b1101;
    nb = 0;
    for (int c = 1; c <= n && nb < 4; c++) begin
      if (g_val[c] === 1'b1) begin
        lit($sformatf("first_packet_bit%0d", nb), int'(g_dat[c]), int'(t1_bits[3 - nb]));
        nb++;
      end
    end
    lit("first_packet_bit_count", nb, 4);

    first_eop = -1;
    for (int c = 1; c <= n; c++) begin
      if (first_eop < 0 && g_eop[c] === 1'b1) first_eop = c;
    end
    if (first_eop > 0) begin
      lit("eop_cycle_active", int'(g_act[first_eop]), 1);
      lit("after_eop_active", int'(g_act[first_eop + 1]), 0);
    end else begin
      lit("eop_found", 0, 1);
    end

    lit("mid_reset_outputs",
        int'({g_sop[mid_rst_idx+1], g_eop[mid_rst_idx+1], g_err[mid_rst_idx+1],
              g_act[mid_rst_idx+1], g_val[mid_rst_idx+1], g_dat[mid_rst_idx+1]}), 0);
    lit("pre_reset_data", int'(g_dat[mid_rst_idx]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
